// File: rtl/rotate_shift_pipe_if.sv
//==============================================================================
// Module  : rotate_shift_pipe_if
// Brief   : Operand/result handshake bundle for rotate_shift_pipe
//           (flag outputs present only with ROTATE_SHIFT_FLAGS_EN).
// Revision: 1.0
//==============================================================================
`default_nettype none

interface rotate_shift_pipe_if #(
    parameter int WIDTH = 32
);
    localparam int AMT_W = $clog2(WIDTH);

    logic             in_valid;
    logic             out_ready;
    logic [WIDTH-1:0] in_x;
    logic [AMT_W-1:0] in_amt;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             in_ready_dn;
    logic [WIDTH-1:0] out_result;
`ifdef ROTATE_SHIFT_FLAGS_EN
    logic             out_zero;
    logic             out_neg;

    modport master (
        output in_valid, in_x, in_amt, in_op, in_ready_dn,
        input  out_ready, out_valid, out_result, out_zero, out_neg
    );
    modport slave (
        input  in_valid, in_x, in_amt, in_op, in_ready_dn,
        output out_ready, out_valid, out_result, out_zero, out_neg
    );
`else
    modport master (
        output in_valid, in_x, in_amt, in_op, in_ready_dn,
        input  out_ready, out_valid, out_result
    );
    modport slave (
        input  in_valid, in_x, in_amt, in_op, in_ready_dn,
        output out_ready, out_valid, out_result
    );
`endif

endinterface

`default_nettype wire

// File: rtl/rotate_shift_pipe.sv
//==============================================================================
// Module  : rotate_shift_pipe
// Brief   : Pipelined barrel rotator/shifter, one stage per amount bit, with a
//           global-stall valid/ready handshake. Macro ROTATE_SHIFT_FLAGS_EN
//           adds registered zero/negative result flags.
// Revision: 1.0
//==============================================================================
`default_nettype none

module rotate_shift_pipe #(
    parameter int WIDTH = 32
) (
    input  wire logic          in_clk,
    input  wire logic          in_rst_n,
    rotate_shift_pipe_if.slave bus
);
    localparam int AMT_W = $clog2(WIDTH);

    localparam logic [2:0] c_op_rol  = 3'b000;
    localparam logic [2:0] c_op_ror  = 3'b001;
    localparam logic [2:0] c_op_shl  = 3'b010;
    localparam logic [2:0] c_op_shr  = 3'b011;
    localparam logic [2:0] c_op_shra = 3'b100;

    // Stage inputs (w_cur_*), stage results (w_next) and stage registers (r_*).
    // The last stage carries no op/amount since nothing downstream needs them.
    logic [WIDTH-1:0] w_cur_data  [AMT_W];
    logic [2:0]       w_cur_op    [AMT_W];
    logic [AMT_W-1:0] w_cur_amt   [AMT_W];
    logic [AMT_W-1:0] w_cur_valid;
    logic [WIDTH-1:0] w_next      [AMT_W];
    logic             w_adv;

    logic [WIDTH-1:0] r_data  [AMT_W];
    logic [2:0]       r_op    [AMT_W-1];
    logic [AMT_W-1:0] r_amt   [AMT_W-1];
    logic [AMT_W-1:0] r_valid;

    function automatic logic [WIDTH-1:0] stage_move(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic             en,
        input int               sh
    );
        logic [WIDTH-1:0] res;
        res = d;
        if (en) begin
            case (op)
                c_op_rol:  res = (d << sh) | (d >> (WIDTH - sh));
                c_op_ror:  res = (d >> sh) | (d << (WIDTH - sh));
                c_op_shl:  res = d << sh;
                c_op_shr:  res = d >> sh;
                c_op_shra: res = $unsigned($signed(d) >>> sh);
                default:   res = d;
            endcase
        end
        return res;
    endfunction

    // Remaining amount is shifted down each stage, so bit 0 is always the
    // bit belonging to the stage currently consuming it.
    genvar k;
    generate
        for (k = 0; k < AMT_W; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign w_cur_data[k]  = bus.in_x;
                assign w_cur_op[k]    = bus.in_op;
                assign w_cur_amt[k]   = bus.in_amt;
                assign w_cur_valid[k] = bus.in_valid;
            end else begin : g_tail
                assign w_cur_data[k]  = r_data[k-1];
                assign w_cur_op[k]    = r_op[k-1];
                assign w_cur_amt[k]   = r_amt[k-1];
                assign w_cur_valid[k] = r_valid[k-1];
            end
            assign w_next[k] = stage_move(w_cur_data[k], w_cur_op[k],
                                          w_cur_amt[k][0], 1 << k);
        end
    endgenerate

    assign w_adv = !(r_valid[AMT_W-1] && !bus.in_ready_dn);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < AMT_W; i++) begin
                r_data[i] <= '0;
            end
            for (int i = 0; i < AMT_W - 1; i++) begin
                r_op[i]  <= '0;
                r_amt[i] <= '0;
            end
        end else if (w_adv) begin
            r_valid <= w_cur_valid;
            for (int i = 0; i < AMT_W; i++) begin
                r_data[i] <= w_next[i];
            end
            for (int i = 0; i < AMT_W - 1; i++) begin
                r_op[i]  <= w_cur_op[i];
                r_amt[i] <= w_cur_amt[i] >> 1;
            end
        end
    end

    assign bus.out_ready  = w_adv;
    assign bus.out_valid  = r_valid[AMT_W-1];
    assign bus.out_result = r_data[AMT_W-1];

`ifdef ROTATE_SHIFT_FLAGS_EN
    logic r_zero;
    logic r_neg;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_adv) begin
            r_zero <= (w_next[AMT_W-1] == '0);
            r_neg  <= w_next[AMT_W-1][WIDTH-1];
        end
    end

    assign bus.out_zero = r_zero;
    assign bus.out_neg  = r_neg;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rotate_shift_pipe.sv
//==============================================================================
// Module  : tb_rotate_shift_pipe
// Brief   : Directed self-checking bench for rotate_shift_pipe (WIDTH=32).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_rotate_shift_pipe;
    localparam int WIDTH = 32;
    localparam int AMT_W = $clog2(WIDTH);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rotate_shift_pipe_if #(.WIDTH(WIDTH)) bus();

    rotate_shift_pipe #(.WIDTH(WIDTH)) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] v_x   [8];
    logic [AMT_W-1:0] v_amt [8];
    logic [2:0]       v_op  [8];
    logic [WIDTH-1:0] v_exp [8];

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] x,
                         input logic [AMT_W-1:0] amt, input logic [2:0] op);
        bus.in_valid = v;
        bus.in_x     = x;
        bus.in_amt   = amt;
        bus.in_op    = op;
    endtask

    // Presents n vectors on consecutive cycles; returns #1 after the n-th edge.
    task automatic issue_burst(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, v_x[i], v_amt[i], v_op[i]);
            wait_edges(1);
        end
        drive(1'b0, '0, '0, 3'b000);
    endtask

    task automatic test_reset;
        drive(1'b0, '0, '0, 3'b000);
        bus.in_ready_dn = 1'b1;
        rst_n = 1'b0;
        wait_edges(3);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %0b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out_result !== 32'h0) begin
            errors++; $display("FAIL reset_result got %h want 00000000", bus.out_result);
        end
        checks++;
        if (bus.out_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %0b want 1", bus.out_ready);
        end
`ifdef ROTATE_SHIFT_FLAGS_EN
        checks++;
        if (bus.out_zero !== 1'b0 || bus.out_neg !== 1'b0) begin
            errors++; $display("FAIL reset_flags got z=%0b n=%0b want 0 0", bus.out_zero, bus.out_neg);
        end
`endif
        rst_n = 1'b1;
        wait_edges(1);
    endtask

    task automatic test_rol;
        drive(1'b1, 32'h8000_0001, 5'd1, 3'b000);
        wait_edges(1);
        drive(1'b0, '0, '0, 3'b000);
        wait_edges(3);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL rol_early_valid got %0b want 0 after 4 edges", bus.out_valid);
        end
        wait_edges(1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h0000_0003) begin
            errors++; $display("FAIL rol_result got v=%0b %h want v=1 00000003", bus.out_valid, bus.out_result);
        end
        wait_edges(1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL rol_consumed got %0b want 0", bus.out_valid);
        end
    endtask

    task automatic test_ror_shra;
        v_x[0] = 32'h0000_0001; v_amt[0] = 5'd4;  v_op[0] = 3'b001; v_exp[0] = 32'h1000_0000;
        v_x[1] = 32'h8000_0000; v_amt[1] = 5'd31; v_op[1] = 3'b100; v_exp[1] = 32'hFFFF_FFFF;
        issue_burst(2);
        wait_edges(3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== v_exp[i]) begin
                errors++; $display("FAIL ror_shra[%0d] got v=%0b %h want v=1 %h", i, bus.out_valid, bus.out_result, v_exp[i]);
            end
            wait_edges(1);
        end
    endtask

    task automatic test_back_to_back;
        v_x[0] = 32'h1234_5678; v_amt[0] = 5'd8; v_op[0] = 3'b010; v_exp[0] = 32'h3456_7800;
        v_x[1] = 32'h1234_5678; v_amt[1] = 5'd8; v_op[1] = 3'b011; v_exp[1] = 32'h0012_3456;
        v_x[2] = 32'h1234_5678; v_amt[2] = 5'd0; v_op[2] = 3'b011; v_exp[2] = 32'h1234_5678;
        issue_burst(3);
        wait_edges(2);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== v_exp[i]) begin
                errors++; $display("FAIL back_to_back[%0d] got v=%0b %h want v=1 %h", i, bus.out_valid, bus.out_result, v_exp[i]);
            end
            wait_edges(1);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL back_to_back_tail got %0b want 0", bus.out_valid);
        end
    endtask

    task automatic test_boundary;
        v_x[0] = 32'h8000_0001; v_amt[0] = 5'd31; v_op[0] = 3'b000; v_exp[0] = 32'hC000_0000;
        v_x[1] = 32'h0000_0003; v_amt[1] = 5'd31; v_op[1] = 3'b010; v_exp[1] = 32'h8000_0000;
        v_x[2] = 32'h4000_0000; v_amt[2] = 5'd31; v_op[2] = 3'b100; v_exp[2] = 32'h0000_0000;
        v_x[3] = 32'hDEAD_BEEF; v_amt[3] = 5'd17; v_op[3] = 3'b101; v_exp[3] = 32'hDEAD_BEEF;
        v_x[4] = 32'hA5A5_A5A5; v_amt[4] = 5'd0;  v_op[4] = 3'b001; v_exp[4] = 32'hA5A5_A5A5;
        issue_burst(5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== v_exp[i]) begin
                errors++; $display("FAIL boundary[%0d] got v=%0b %h want v=1 %h", i, bus.out_valid, bus.out_result, v_exp[i]);
            end
            wait_edges(1);
        end
    endtask

    task automatic test_backpressure;
        int idx;
        int got;
        int cyc;
        idx = 0;
        got = 0;
        cyc = 1;
        for (int i = 0; i < 8; i++) begin
            v_x[i]   = WIDTH'(i + 1);
            v_amt[i] = 5'd4;
            v_op[i]  = 3'b010;
        end
        v_exp[0] = 32'h10; v_exp[1] = 32'h20; v_exp[2] = 32'h30; v_exp[3] = 32'h40;
        v_exp[4] = 32'h50; v_exp[5] = 32'h60; v_exp[6] = 32'h70; v_exp[7] = 32'h80;
        while (got < 8 && cyc <= 60) begin
            bus.in_ready_dn = !(cyc >= 6 && cyc <= 9);
            if (idx < 8) drive(1'b1, v_x[idx], v_amt[idx], v_op[idx]);
            else         drive(1'b0, '0, '0, 3'b000);
            @(negedge clk);
            if (cyc >= 6 && cyc <= 9) begin
                checks++;
                if (bus.out_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== 32'h10) begin
                    errors++; $display("FAIL stall_cyc%0d got rdy=%0b v=%0b %h want rdy=0 v=1 00000010",
                                       cyc, bus.out_ready, bus.out_valid, bus.out_result);
                end
            end
            if (bus.in_valid && bus.out_ready) idx++;
            if (bus.out_valid && bus.in_ready_dn) begin
                checks++;
                if (bus.out_result !== v_exp[got]) begin
                    errors++; $display("FAIL stream[%0d] got %h want %h", got, bus.out_result, v_exp[got]);
                end
                got++;
            end
            wait_edges(1);
            cyc++;
        end
        bus.in_ready_dn = 1'b1;
        drive(1'b0, '0, '0, 3'b000);
        checks++;
        if (got != 8) begin
            errors++; $display("FAIL stream_count got %0d want 8", got);
        end
        wait_edges(6);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_extra got v=%0b want 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_midflight;
        int leaks;
        leaks = 0;
        for (int i = 0; i < 3; i++) begin
            v_x[i] = 32'hFFFF_0000; v_amt[i] = 5'd3; v_op[i] = 3'b001;
        end
        issue_burst(3);
        wait_edges(1);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0) begin
            errors++; $display("FAIL midreset_now got v=%0b %h want v=0 00000000", bus.out_valid, bus.out_result);
        end
        #8 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid !== 1'b0) leaks++;
            wait_edges(1);
        end
        checks++;
        if (leaks != 0) begin
            errors++; $display("FAIL midreset_leak got %0d valid cycles want 0", leaks);
        end
        drive(1'b1, 32'h0000_00F0, 5'd4, 3'b011);
        wait_edges(1);
        drive(1'b0, '0, '0, 3'b000);
        wait_edges(3);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_early got %0b want 0", bus.out_valid);
        end
        wait_edges(1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h0000_000F) begin
            errors++; $display("FAIL midreset_new got v=%0b %h want v=1 0000000f", bus.out_valid, bus.out_result);
        end
        wait_edges(1);
    endtask

`ifdef ROTATE_SHIFT_FLAGS_EN
    task automatic test_flags;
        v_x[0] = 32'h0000_0001; v_amt[0] = 5'd1; v_op[0] = 3'b011; v_exp[0] = 32'h0000_0000;
        v_x[1] = 32'h8000_0000; v_amt[1] = 5'd4; v_op[1] = 3'b100; v_exp[1] = 32'hF800_0000;
        issue_burst(2);
        wait_edges(3);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== v_exp[0] || bus.out_zero !== 1'b1 || bus.out_neg !== 1'b0) begin
            errors++; $display("FAIL flags_zero got v=%0b %h z=%0b n=%0b want v=1 00000000 z=1 n=0",
                               bus.out_valid, bus.out_result, bus.out_zero, bus.out_neg);
        end
        wait_edges(1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== v_exp[1] || bus.out_zero !== 1'b0 || bus.out_neg !== 1'b1) begin
            errors++; $display("FAIL flags_neg got v=%0b %h z=%0b n=%0b want v=1 f8000000 z=0 n=1",
                               bus.out_valid, bus.out_result, bus.out_zero, bus.out_neg);
        end
        wait_edges(1);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rol();
        test_ror_shra();
        test_back_to_back();
        test_boundary();
        test_backpressure();
        test_reset_midflight();
`ifdef ROTATE_SHIFT_FLAGS_EN
        test_flags();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rotate_shift_pipe.md
Name: rotate_shift_pipe

Overview:
- Parametrised, pipelined successor to the combinational 32-bit left rotator.
- Adds rotate right, logical shifts and arithmetic right shift, plus a width parameter.
- Registers one barrel stage per amount bit and carries a valid/ready handshake through the pipeline.
- Sits between the ALU operand muxes and the result register for ROL/ROR/SHL/SHR/SHRA instructions.

Parameters:
- WIDTH, 32, data width in bits. Must be a power of 2 and at least 4.
- AMT_W, derived local parameter equal to log2(WIDTH). Shift-amount width and pipeline stage count. Not overridable.

Ports:
- in_clk  input  1  clock; all state updates on the rising edge.
- in_rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents an operation.
- out_ready  output  1  block accepts the operation this cycle.
- in_x  input  WIDTH  operand.
- in_amt  input  AMT_W  shift/rotate amount, 0..WIDTH-1.
- in_op  input  3  operation: 000 ROL, 001 ROR, 010 SHL, 011 SHR, 100 SHRA, 101-111 pass-through.
- out_valid  output  1  out_result is valid.
- in_ready_dn  input  1  downstream accepts out_result.
- out_result  output  WIDTH  shifted/rotated value.

Behaviour:
- Reset:
  - Asynchronous on in_rst_n low.
  - All stage valid bits, data, op and amount registers clear to 0.
  - out_valid=0 and out_result=0 while in reset.
  - Reset mid-operation discards every in-flight operation; no partial result is ever emitted.
- Pipeline structure:
  - Stages 0..AMT_W-1.
  - Stage k conditionally moves data by 2^k when in_amt bit k is set; otherwise it passes data unchanged.
  - Each stage registers: data, op, remaining amount bits, valid.
- Stage operations:
  - ROL: bits leaving the MSB re-enter at the LSB.
  - ROR: bits leaving the LSB re-enter at the MSB.
  - SHL: zero fill at the LSB.
  - SHR: zero fill at the MSB.
  - SHRA: fill at the MSB with the current MSB. This equals the original sign because the MSB never changes under SHRA.
  - Pass-through codes: data unchanged in all stages.
- Latency: exactly AMT_W cycles from acceptance to out_valid. This is 5 for WIDTH=32. Throughput is 1 operation per cycle when not stalled.
- Stall (global enable):
  - adv = !(out_valid && !in_ready_dn).
  - When adv=0, all stage registers hold, including data and valid bits.
  - out_ready = adv. An operation is accepted when in_valid && out_ready.
  - Bubbles (invalid stages) are not compressed during stall.
- Output: out_result is held stable while out_valid=1 and in_ready_dn=0. A result is consumed when out_valid && in_ready_dn.
- Boundary conditions:
  - in_amt=0 returns in_x unchanged for every op, still after AMT_W cycles.
  - in_amt=WIDTH-1 is the maximum amount; no wrap beyond this range is possible.
  - When a new acceptance and a final-stage consumption occur in the same cycle, both take effect.
  - in_valid=0 while adv=1 inserts a bubble, with stage-0 valid set to 0.
- No combinational path from any input to out_result or out_valid. out_ready depends combinationally on in_ready_dn and out_valid only.

Optional Feature:
- Macro: ROTATE_SHIFT_FLAGS_EN.
- When defined, the block adds two outputs, registered in the final stage alongside out_result:
  - out_zero (1): high when out_result == 0.
  - out_neg (1): equals out_result[WIDTH-1].
  - Both reset to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=32, single ROL: in_x=0x80000001, in_amt=1, in_op=000 -> after 5 cycles out_valid=1, out_result=0x00000003.
- ROR and SHRA:
  - in_x=0x00000001, amt=4, op=001 -> out_result=0x10000000.
  - Next cycle, in_x=0x80000000, amt=31, op=100 -> 0xFFFFFFFF.
- SHL/SHR back-to-back with zero amount: in_x=0x12345678 under each of the following, issued on consecutive cycles:
  - op=010, amt=8 -> 0x34567800.
  - op=011, amt=8 -> 0x00123456.
  - op=011, amt=0 -> 0x12345678.
  - Results appear on consecutive cycles.
- Backpressure: stream 8 ops with in_ready_dn=0 from cycle 6 to 9.
  - out_ready=0 for cycles 6-9, and out_result is held.
  - All 8 results delivered in order; none lost or duplicated.
- Reset mid-flight: accept 3 ops, then pulse in_rst_n low for 1 cycle asynchronously -> out_valid=0 immediately and stays 0 until new ops have traversed 5 stages.
- Flags (ROTATE_SHIFT_FLAGS_EN defined): in_x=0x00000001, op=011, amt=1 -> out_result=0, out_zero=1, out_neg=0.
